// File: rtl/proc_isa_pkg.sv
// ---------------------------------------------------------------------------
// proc_isa_pkg
// Shared definitions for the 8-bit mv/mvi/add/sub processor and its program
// loader/server: opcode encodings, the opcode field position, error bit
// indices and the loader state encoding.
// ---------------------------------------------------------------------------
package proc_isa_pkg;

   localparam logic [1:0] OP_MV  = 2'b00;
   localparam logic [1:0] OP_MVI = 2'b01;   // next word is an immediate
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   localparam int OPC_MSB = 7;
   localparam int OPC_LSB = 6;

   localparam int ERR_OVF    = 0;           // program longer than the RAM
   localparam int ERR_DANGLE = 1;           // program ends on an mvi opcode

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // Opcode field of an instruction word.
   function automatic logic [1:0] opcode_of(input logic [7:0] word);
      return word[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/prog_ram.sv
// ---------------------------------------------------------------------------
// prog_ram
// DEPTH x 8 instruction RAM: one synchronous write port and one registered
// read port. Deliberately has no reset so it maps onto block/distributed RAM.
//
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata updates on the next edge
//   raddr  in   read address
//   rdata  out  registered read data (holds when re is low)
// ---------------------------------------------------------------------------
module prog_ram #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem_r [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read port.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem_r[raddr];
      end
   end

endmodule

// File: rtl/prog_loader_server.sv
// ---------------------------------------------------------------------------
// prog_loader_server
// Program-side partner of the 8-bit mv/mvi/add/sub processor. A program is
// streamed in on a valid/ready load port, stored in an internal RAM, checked
// for mvi/immediate pairing, and then served back word by word on a req/valid
// fetch port with wrap-around addressing.
//
// Optional build macro: LOAD_CHECKSUM_EN adds ld_sum, the mod-256 sum of all
// accepted load words.
//
// Ports:
//   CLOCK_50      in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   start_load    in   pulse: begin a new program load (from any state)
//   ld_valid      in   load word present
//   ld_data       in   instruction or immediate word
//   ld_last       in   ld_data is the final program word
//   ld_ready      out  load word can be accepted
//   fetch_req     in   request next instruction word
//   fetch_valid   out  one-cycle response pulse
//   fetch_data    out  returned word
//   fetch_addr    out  address of the returned word
//   fetch_is_imm  out  returned word is the immediate of a preceding mvi
//   prog_len      out  number of words loaded (1..DEPTH)
//   running       out  serving fetches
//   err           out  bit0 overflow, bit1 dangling mvi (sticky)
//   ld_sum        out  (LOAD_CHECKSUM_EN only) sum of accepted load words
// ---------------------------------------------------------------------------
module prog_loader_server
   import proc_isa_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          start_load,
   input  logic          ld_valid,
   input  logic [7:0]    ld_data,
   input  logic          ld_last,
   output logic          ld_ready,
   input  logic          fetch_req,
   output logic          fetch_valid,
   output logic [7:0]    fetch_data,
   output logic [AW-1:0] fetch_addr,
   output logic          fetch_is_imm,
   output logic [AW:0]   prog_len,
   output logic          running,
`ifdef LOAD_CHECKSUM_EN
   output logic [7:0]    ld_sum,
`endif
   output logic [1:0]    err
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] ZERO_ADDR = AW'(0);
   localparam logic [AW-1:0] ONE_ADDR  = AW'(1);
   localparam logic [AW:0]   FULL_LEN  = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   ONE_LEN   = (AW + 1)'(1);

   state_t        state_r;
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic          ld_imm_pending_r;
   logic          imm_track_r;
   logic          ld_ready_r;
   logic          fetch_valid_r;
   logic [AW-1:0] fetch_addr_r;
   logic          fetch_is_imm_r;
   logic [AW:0]   prog_len_r;
   logic          running_r;
   logic [1:0]    err_r;

   logic          ld_accept_s;
   logic          ld_is_mvi_s;
   logic          ld_term_s;
   logic          fetch_accept_s;
   logic          rd_wrap_s;
   logic          imm_track_s;
   logic [7:0]    ram_q_s;

   // Load-side handshake decode; start_load masks any accept in its cycle.
   always_comb begin
      ld_accept_s = 1'b0;
      ld_is_mvi_s = 1'b0;
      ld_term_s   = 1'b0;
      if ((state_r == ST_LOAD) && ld_ready_r && ld_valid && !start_load) begin
         ld_accept_s = 1'b1;
         // A word following an mvi is an immediate and never decoded.
         ld_is_mvi_s = (opcode_of(ld_data) == OP_MVI) && !ld_imm_pending_r;
         ld_term_s   = ld_last || (wr_ptr_r == LAST_ADDR);
      end else begin
         ld_accept_s = 1'b0;
      end
   end

   // Fetch-side decode and the immediate tracker for the next response.
   always_comb begin
      fetch_accept_s = 1'b0;
      rd_wrap_s      = 1'b0;
      imm_track_s    = imm_track_r;
      if ((state_r == ST_RUN) && fetch_req && !start_load) begin
         fetch_accept_s = 1'b1;
      end else begin
         fetch_accept_s = 1'b0;
      end
      rd_wrap_s = (({1'b0, rd_ptr_r} + ONE_LEN) == prog_len_r);
      // The word just returned decides whether the next word is an immediate.
      if (fetch_valid_r) begin
         imm_track_s = (opcode_of(ram_q_s) == OP_MVI) && !fetch_is_imm_r;
      end else begin
         imm_track_s = imm_track_r;
      end
   end

   // Main control FSM: load sequencing, error capture and fetch pipeline.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_r          <= ST_IDLE;
         wr_ptr_r         <= ZERO_ADDR;
         rd_ptr_r         <= ZERO_ADDR;
         ld_imm_pending_r <= 1'b0;
         imm_track_r      <= 1'b0;
         ld_ready_r       <= 1'b0;
         fetch_valid_r    <= 1'b0;
         fetch_addr_r     <= ZERO_ADDR;
         fetch_is_imm_r   <= 1'b0;
         prog_len_r       <= '0;
         running_r        <= 1'b0;
         err_r            <= 2'b00;
      end else if (start_load) begin
         state_r          <= ST_LOAD;
         wr_ptr_r         <= ZERO_ADDR;
         rd_ptr_r         <= ZERO_ADDR;
         ld_imm_pending_r <= 1'b0;
         imm_track_r      <= 1'b0;
         ld_ready_r       <= 1'b0;
         fetch_valid_r    <= 1'b0;
         fetch_addr_r     <= ZERO_ADDR;
         fetch_is_imm_r   <= 1'b0;
         prog_len_r       <= '0;
         running_r        <= 1'b0;
         err_r            <= 2'b00;
      end else begin
         case (state_r)
            ST_IDLE: begin
               ld_ready_r    <= 1'b0;
               fetch_valid_r <= 1'b0;
            end
            ST_LOAD: begin
               fetch_valid_r <= 1'b0;
               if (ld_accept_s) begin
                  wr_ptr_r         <= wr_ptr_r + ONE_ADDR;
                  ld_imm_pending_r <= ld_is_mvi_s;
               end
               if (ld_term_s) begin
                  state_r    <= ST_RUN;
                  running_r  <= 1'b1;
                  ld_ready_r <= 1'b0;
                  // wr_ptr+1 reaches DEPTH on the last slot, so one formula
                  // covers both the ld_last and the overflow case.
                  prog_len_r <= {1'b0, wr_ptr_r} + ONE_LEN;
                  err_r[ERR_OVF]    <= err_r[ERR_OVF] | !ld_last;
                  err_r[ERR_DANGLE] <= err_r[ERR_DANGLE] | ld_is_mvi_s;
               end else begin
                  ld_ready_r <= 1'b1;
               end
            end
            ST_RUN: begin
               fetch_valid_r <= fetch_accept_s;
               imm_track_r   <= imm_track_s;
               if (fetch_accept_s) begin
                  fetch_addr_r <= rd_ptr_r;
                  // Word 0 is never an immediate: the tracker clears on wrap.
                  fetch_is_imm_r <= (rd_ptr_r == ZERO_ADDR) ? 1'b0 : imm_track_s;
                  rd_ptr_r <= rd_wrap_s ? ZERO_ADDR : (rd_ptr_r + ONE_ADDR);
               end else begin
                  fetch_is_imm_r <= 1'b0;
               end
            end
            default: begin
               state_r       <= ST_IDLE;
               ld_ready_r    <= 1'b0;
               fetch_valid_r <= 1'b0;
               running_r     <= 1'b0;
            end
         endcase
      end
   end

`ifdef LOAD_CHECKSUM_EN
   logic [7:0] ld_sum_r;

   // Running mod-256 sum of accepted load words; frozen outside LOAD.
   always_ff @(posedge CLOCK_50) begin
      if (reset || start_load) begin
         ld_sum_r <= 8'h00;
      end else if (ld_accept_s) begin
         ld_sum_r <= ld_sum_r + ld_data;
      end
   end

   assign ld_sum = ld_sum_r;
`endif

   prog_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (CLOCK_50),
      .we    (ld_accept_s),
      .waddr (wr_ptr_r),
      .wdata (ld_data),
      .re    (fetch_accept_s),
      .raddr (rd_ptr_r),
      .rdata (ram_q_s)
   );

   assign ld_ready     = ld_ready_r;
   assign fetch_valid  = fetch_valid_r;
   // RAM read register has no reset; mask it so fetch_data is 0 when idle.
   assign fetch_data   = ram_q_s & {8{fetch_valid_r}};
   assign fetch_addr   = fetch_addr_r;
   assign fetch_is_imm = fetch_is_imm_r;
   assign prog_len     = prog_len_r;
   assign running      = running_r;
   assign err          = err_r;

endmodule
